bp_pht_sched: RTL

Controller for the global-history PHT (2-bit counters, 1R1W table) in the branch-prediction path. It owns the table's write port and shares its read port between the fetch-stage lookup (priority) and its own read-modify-write updates, which are queued from the M stage. It replaces a reset-time loop over the whole table with a counted init sweep, and supports a software-triggered re-init.

---
 rtl/bp_pkg.sv | 10 +
 rtl/bp_upd_fifo.sv | 40 ++++
 rtl/bp_pht_sched.sv | 102 ++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared branch-predictor types, defaults and 2-bit counter update rule.
package bp_pkg;
    typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b11, ST = 2'b10} ctr_e;
    typedef enum logic {S_INIT, S_RUN} sched_state_e;
    localparam int PHT_DEPTH_DEF = 14;
    function automatic logic [1:0] next_counter(input logic [1:0] s, input logic t);
        return t ? (s == SNT ? WNT : s == WNT ? WT : ST)
                 : (s == ST ? WT : s == WT ? WNT : SNT);
    endfunction
endpackage

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo: synchronous FIFO with occupancy count, simultaneous push/pop and flush.
// Ports: flush_i empties the queue; push_i/din_i enqueue; pop_i dequeues dout_o (head);
//        count_o is the occupancy, empty_o flags count_o == 0.
// The caller never pushes into a full queue unless it pops in the same cycle.
module bp_upd_fifo #(
    parameter int W = 15,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic [AW:0]   count_o,
    output logic          empty_o
);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] rp_q, wp_q;
    logic [AW:0] cnt_q;
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wp_q] <= din_i;
    end
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rp_q <= '0;
            wp_q <= '0;
            cnt_q <= '0;
        end else begin
            wp_q <= wp_q + AW'(push_i);
            rp_q <= rp_q + AW'(pop_i);
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end
    assign dout_o = mem_q[rp_q];
    assign count_o = cnt_q;
    assign empty_o = cnt_q == '0;
endmodule

// File: rtl/bp_pht_sched.sv
// bp_pht_sched: PHT controller - init sweep, shared read port, queued read-modify-write updates.
// Ports: lk_req/lk_index/lk_taken fetch lookup; upd_valid/upd_index/upd_taken M-stage updates;
//        clear_req re-init pulse; tbl_raddr/tbl_rdata read port; tbl_we/tbl_waddr/tbl_wdata
//        write port; init_done table valid; drop_cnt saturating count of dropped updates.
module bp_pht_sched
    import bp_pkg::*;
#(
    parameter int PHT_DEPTH = PHT_DEPTH_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter logic [1:0] INIT_STATE = 2'b11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lk_req,
    input  logic [PHT_DEPTH-1:0] lk_index,
    output logic                 lk_taken,
    input  logic                 upd_valid,
    input  logic [PHT_DEPTH-1:0] upd_index,
    input  logic                 upd_taken,
    input  logic                 clear_req,
    output logic [PHT_DEPTH-1:0] tbl_raddr,
    input  logic [1:0]           tbl_rdata,
    output logic                 tbl_we,
    output logic [PHT_DEPTH-1:0] tbl_waddr,
    output logic [1:0]           tbl_wdata,
    output logic                 init_done,
    output logic [15:0]          drop_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    sched_state_e state_q, state_d;
    logic [PHT_DEPTH-1:0] cnt_q, cnt_d, s1_idx_q, s1_idx_d;
    logic s1_v_q, s1_v_d, s1_tk_q, s1_tk_d;
    logic [1:0] s1_ctr_q, s1_ctr_d, upd_wdata;
    logic [15:0] drop_q, drop_d;
    logic run, pop, acc, push, drop, empty;
    logic [PHT_DEPTH:0] head;
    logic [CW-1:0] count;

    assign run = state_q == S_RUN;
    assign pop = run & ~clear_req & ~empty & ~lk_req;
    assign acc = (count < CW'(FIFO_DEPTH)) | pop;
    assign push = run & ~clear_req & upd_valid & acc;
    assign drop = run & ~clear_req & upd_valid & ~acc;
    assign upd_wdata = next_counter(s1_ctr_q, s1_tk_q);

    bp_upd_fifo #(.W(PHT_DEPTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (run & clear_req),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({upd_index, upd_taken}),
        .dout_o  (head),
        .count_o (count),
        .empty_o (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_INIT;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = run ? (clear_req ? S_INIT : S_RUN) : (&cnt_q ? S_RUN : S_INIT);
    end

    always_comb begin
        tbl_we = ~rst & (run ? s1_v_q & ~clear_req : 1'b1);
        tbl_waddr = run ? s1_idx_q : cnt_q;
        tbl_wdata = run ? upd_wdata : INIT_STATE;
        tbl_raddr = (run & ~lk_req) ? head[PHT_DEPTH:1] : lk_index;
        lk_taken = lk_req & run & tbl_rdata[1];
        init_done = run;
    end

    // A pop reading the index S1 writes this cycle must see the new value, not the stale RAM data.
    always_comb begin
        cnt_d = run ? '0 : cnt_q + 1'b1;
        s1_v_d = pop;
        s1_idx_d = head[PHT_DEPTH:1];
        s1_tk_d = head[0];
        s1_ctr_d = (s1_v_q && s1_idx_q == head[PHT_DEPTH:1]) ? upd_wdata : tbl_rdata;
        drop_d = (drop && drop_q != 16'hFFFF) ? drop_q + 1'b1 : drop_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            s1_v_q <= 1'b0;
            drop_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            s1_v_q <= s1_v_d;
            drop_q <= drop_d;
        end
        s1_idx_q <= s1_idx_d;
        s1_tk_q <= s1_tk_d;
        s1_ctr_q <= s1_ctr_d;
    end

    assign drop_cnt = drop_q;
endmodule
